// File: rtl/alu8_issue.sv
// alu8_issue: issue/sequencing controller for an external 8-bit ALU slice.
// Latches a request, drives the slice from registers, derives carry/overflow
// flags, runs SLT as a two-pass sequence and holds the response until taken.
module alu8_issue (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       in_valid,
    output logic       in_ready,
    input  logic [7:0] in_src1,
    input  logic [7:0] in_src2,
    input  logic [3:0] in_op,
    output logic [7:0] alu_src1,
    output logic [7:0] alu_src2,
    output logic       alu_less,
    output logic       alu_A_invert,
    output logic       alu_B_invert,
    output logic       alu_cin,
    output logic [1:0] alu_operation,
    input  logic [7:0] alu_result,
    input  logic       alu_P,
    input  logic       alu_G,
    output logic       out_valid,
    input  logic       out_ready,
    output logic [7:0] out_result,
    output logic       out_zero,
    output logic       out_cout,
    output logic       out_overflow,
    output logic       out_err
);

    localparam int unsigned W    = 8;
    localparam int unsigned OP_W = 2;

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] EXEC = 2'd1;
    localparam logic [1:0] SLT2 = 2'd2;
    localparam logic [1:0] DONE = 2'd3;

    localparam logic [3:0] OP_AND = 4'b0000;
    localparam logic [3:0] OP_OR  = 4'b0001;
    localparam logic [3:0] OP_ADD = 4'b0010;
    localparam logic [3:0] OP_SUB = 4'b0110;
    localparam logic [3:0] OP_SLT = 4'b0111;
    localparam logic [3:0] OP_NOR = 4'b1100;

    localparam logic [OP_W-1:0] ALU_AND  = 2'b00;
    localparam logic [OP_W-1:0] ALU_OR   = 2'b01;
    localparam logic [OP_W-1:0] ALU_ADD  = 2'b10;
    localparam logic [OP_W-1:0] ALU_LESS = 2'b11;

    logic [1:0]      state_q, state_d;
    logic [W-1:0]    src1_q, src1_d, src2_q, src2_d;
    logic            a_inv_q, a_inv_d, b_inv_q, b_inv_d, cin_q, cin_d;
    logic [OP_W-1:0] op_q, op_d;
    logic            less_q, less_d, less_bit_q, less_bit_d;
    logic            arith_q, arith_d, slt_q, slt_d;
    logic            in_ready_q, in_ready_d, out_valid_q, out_valid_d;
    logic [W-1:0]    result_q, result_d;
    logic            zero_q, zero_d, cout_q, cout_d, ovf_q, ovf_d, err_q, err_d;

    logic            cout_c, ovf_c, zero_c;

    // Flags derived from the slice response to the latched operands
    assign cout_c = alu_G | (alu_P & cin_q);
    assign ovf_c  = (src1_q[W-1] == (src2_q[W-1] ^ b_inv_q)) && (alu_result[W-1] != src1_q[W-1]);
    assign zero_c = (alu_result == W'(0));

    // Next-state and next-register values
    always_comb begin
        state_d    = state_q;
        src1_d     = src1_q;
        src2_d     = src2_q;
        a_inv_d    = a_inv_q;
        b_inv_d    = b_inv_q;
        cin_d      = cin_q;
        op_d       = op_q;
        less_d     = less_q;
        less_bit_d = less_bit_q;
        arith_d    = arith_q;
        slt_d      = slt_q;
        result_d   = result_q;
        zero_d     = zero_q;
        cout_d     = cout_q;
        ovf_d      = ovf_q;
        err_d      = err_q;

        case (state_q)
            IDLE: begin
                if (in_valid && in_ready_q) begin
                    src1_d  = in_src1;
                    src2_d  = in_src2;
                    a_inv_d = 1'b0;
                    b_inv_d = 1'b0;
                    cin_d   = 1'b0;
                    op_d    = ALU_AND;
                    less_d  = 1'b0;
                    arith_d = 1'b0;
                    slt_d   = 1'b0;
                    err_d   = 1'b0;
                    state_d = EXEC;
                    case (in_op)
                        OP_AND: op_d = ALU_AND;
                        OP_OR:  op_d = ALU_OR;
                        OP_ADD: begin
                            op_d    = ALU_ADD;
                            arith_d = 1'b1;
                        end
                        OP_SUB: begin
                            b_inv_d = 1'b1;
                            cin_d   = 1'b1;
                            op_d    = ALU_ADD;
                            arith_d = 1'b1;
                        end
                        OP_SLT: begin
                            b_inv_d = 1'b1;
                            cin_d   = 1'b1;
                            op_d    = ALU_ADD;
                            slt_d   = 1'b1;
                        end
                        OP_NOR: begin
                            a_inv_d = 1'b1;
                            b_inv_d = 1'b1;
                            op_d    = ALU_AND;
                        end
                        default: begin
                            // Illegal opcode: skip execution, answer with an error
                            result_d = W'(0);
                            zero_d   = 1'b1;
                            cout_d   = 1'b0;
                            ovf_d    = 1'b0;
                            err_d    = 1'b1;
                            state_d  = DONE;
                        end
                    endcase
                end
            end
            EXEC: begin
                if (slt_q) begin
                    // Sign of the difference, corrected for overflow, feeds bit 0
                    less_bit_d = alu_result[W-1] ^ ovf_c;
                    less_d     = alu_result[W-1] ^ ovf_c;
                    op_d       = ALU_LESS;
                    state_d    = SLT2;
                end else begin
                    result_d = alu_result;
                    zero_d   = zero_c;
                    cout_d   = arith_q ? cout_c : 1'b0;
                    ovf_d    = arith_q ? ovf_c : 1'b0;
                    state_d  = DONE;
                end
            end
            SLT2: begin
                result_d = alu_result;
                zero_d   = zero_c;
                cout_d   = 1'b0;
                ovf_d    = 1'b0;
                less_d   = 1'b0;
                state_d  = DONE;
            end
            DONE: begin
                if (out_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase

        in_ready_d  = (state_d == IDLE);
        out_valid_d = (state_d == DONE);
    end

    // State and datapath registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            src1_q      <= W'(0);
            src2_q      <= W'(0);
            a_inv_q     <= 1'b0;
            b_inv_q     <= 1'b0;
            cin_q       <= 1'b0;
            op_q        <= OP_W'(0);
            less_q      <= 1'b0;
            less_bit_q  <= 1'b0;
            arith_q     <= 1'b0;
            slt_q       <= 1'b0;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
            result_q    <= W'(0);
            zero_q      <= 1'b0;
            cout_q      <= 1'b0;
            ovf_q       <= 1'b0;
            err_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            src1_q      <= src1_d;
            src2_q      <= src2_d;
            a_inv_q     <= a_inv_d;
            b_inv_q     <= b_inv_d;
            cin_q       <= cin_d;
            op_q        <= op_d;
            less_q      <= less_d;
            less_bit_q  <= less_bit_d;
            arith_q     <= arith_d;
            slt_q       <= slt_d;
            in_ready_q  <= in_ready_d;
            out_valid_q <= out_valid_d;
            result_q    <= result_d;
            zero_q      <= zero_d;
            cout_q      <= cout_d;
            ovf_q       <= ovf_d;
            err_q       <= err_d;
        end
    end

    assign in_ready      = in_ready_q;
    assign alu_src1      = src1_q;
    assign alu_src2      = src2_q;
    assign alu_less      = less_q;
    assign alu_A_invert  = a_inv_q;
    assign alu_B_invert  = b_inv_q;
    assign alu_cin       = cin_q;
    assign alu_operation = op_q;
    assign out_valid     = out_valid_q;
    assign out_result    = result_q;
    assign out_zero      = zero_q;
    assign out_cout      = cout_q;
    assign out_overflow  = ovf_q;
    assign out_err       = err_q;

endmodule

// File: doc/alu8_issue.md
ALU8_ISSUE -- requirements
Module: alu8_issue

Interface
REQ-001 The block SHALL have one clock and an asynchronous, active-low reset.
REQ-002 Ports SHALL be as follows (name, direction, width, meaning):
- clk  in  1  clock.
- rst_n  in  1  asynchronous active-low reset.
- in_valid  in  1  request valid.
- in_ready  out  1  block can accept a request.
- in_src1  in  8  operand A.
- in_src2  in  8  operand B.
- in_op  in  4  control: 0000 AND, 0001 OR, 0010 ADD, 0110 SUB, 0111 SLT, 1100 NOR.
- alu_src1  out  8  operand A to the 8-bit ALU slice.
- alu_src2  out  8  operand B to the 8-bit ALU slice.
- alu_less  out  1  less input to ALU bit 0.
- alu_A_invert  out  1  A invert control to the ALU.
- alu_B_invert  out  1  B invert control to the ALU.
- alu_cin  out  1  carry in to the ALU.
- alu_operation  out  2  00 AND, 01 OR, 10 ADD, 11 LESS.
- alu_result  in  8  ALU result (combinational from the alu_* outputs).
- alu_P  in  1  ALU group propagate.
- alu_G  in  1  ALU group generate.
- out_valid  out  1  response valid.
- out_ready  in  1  consumer accepts the response.
- out_result  out  8  registered result.
- out_zero  out  1  out_result == 0.
- out_cout  out  1  carry out (ADD/SUB only, else 0).
- out_overflow  out  1  signed overflow (ADD/SUB only, else 0).
- out_err  out  1  in_op was illegal.

Function
REQ-003 The FSM SHALL have exactly four states: IDLE, EXEC, SLT2, DONE; in_ready SHALL be 1 only in IDLE.
REQ-004 On in_valid&&in_ready, the block SHALL latch in_src1, in_src2 and the decoded controls, then move to EXEC; an illegal in_op SHALL go directly to DONE.
REQ-005 Decode (A_inv, B_inv, cin, operation) SHALL be:
- AND = 0,0,0,00
- OR = 0,0,0,01
- ADD = 0,0,0,10
- SUB = 0,1,1,10
- NOR = 1,1,0,00
- SLT = 0,1,1,10 in EXEC, then 0,1,1,11 in SLT2.
REQ-006 alu_* outputs SHALL come only from the latched registers; alu_less SHALL be 0 except in SLT2.
REQ-007 Flags SHALL be computed in EXEC as follows:
- cout = alu_G | (alu_P & alu_cin).
- ovf = (src1[7] == (src2[7]^B_inv)) && (alu_result[7] != src1[7]).
REQ-008 For non-SLT operations, EXEC SHALL capture alu_result, zero, cout and ovf into the out_* registers and go to DONE; cout and ovf SHALL be captured as 0 for non-ADD/SUB operations.
REQ-009 For SLT, EXEC SHALL register less_bit = alu_result[7] ^ ovf and go to SLT2; in SLT2, alu_less SHALL equal less_bit and SLT2 SHALL capture alu_result (0x01 or 0x00), zero, cout=0 and ovf=0, then go to DONE.
REQ-010 Latency from the accept edge to out_valid SHALL be 2 cycles (3 for SLT, 1 for illegal op).
REQ-011 In DONE, out_valid SHALL be 1 and all out_* SHALL be held stable until out_ready; the handshake SHALL return the FSM to IDLE, with no same-cycle re-accept.
REQ-012 An illegal op SHALL produce out_result=0x00, out_zero=1, out_err=1; out_err SHALL be 0 for legal ops.
REQ-013 in_valid while in_ready=0 SHALL be ignored, and the request is not queued.

Reset
REQ-014 While rst_n=0, the block SHALL be in IDLE with every output register (all alu_*, out_*, less_bit) at 0; in_ready SHALL be 1.
REQ-015 Reset asserted in any state SHALL abort the operation at once: out_valid drops without a cycle of delay and no response is produced.

Verification
REQ-016 The bench SHALL cover these directed scenarios:
- ADD 0x7F+0x01 -> out_result 0x80, ovf=1, cout=0, zero=0; out_valid 2 cycles after accept.
- SUB 0x05-0x05 -> 0x00, zero=1, cout=1, ovf=0.
- SLT 0x80,0x01 -> 0x01; SLT 0x7F,0x80 -> 0x00 (overflow-corrected); out_valid 3 cycles after accept; alu_less=1 only during SLT2 of the first case.
- NOR 0x0F,0xF0 -> 0x00, zero=1; OR 0x0F,0xF0 -> 0xFF.
- out_ready held low 5 cycles: outputs stable, in_ready=0, a new in_valid is ignored; after release, in_ready=1 on the next cycle.
- in_op=0101 -> out_err=1, result 0x00 after 1 cycle; rst_n pulsed low during SLT2 -> no out_valid, all outputs 0, IDLE.
